// File: rtl/if_fetch_if.sv
// ----------------------------------------------------------------------------
// if_fetch_if : instruction-fetch bus (rib) between the fetch unit and memory.
//
//   req_valid  master->slave  fetch request valid
//   req_addr   master->slave  fetch address (word aligned)
//   req_ready  slave->master  request accepted this cycle
//   rsp_valid  slave->master  read data returned, in request order
//   rsp_data   slave->master  returned instruction word
// ----------------------------------------------------------------------------
interface if_fetch_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch : instruction fetch unit.
//
// Owns the program counter, issues in-order reads on the rib master port with
// at most two requests in flight, buffers returned words in a 2-entry queue
// and presents the queue head to the IF/ID register. Obeys the controller's
// jump (flush + redirect) and hold (freeze PC / stall consumer) commands.
//
// Ports
//   clk, rst       core clock, asynchronous active-high reset
//   jump_flag_i    redirect request (highest priority)
//   jump_addr_i    redirect target
//   hold_flag_i    hold level: 0 none, 1 Pc, 2 If, 3 Id, 4 Wb
//   rib            fetch bus, master side
//   inst_valid_o   queue head holds a returned instruction
//   inst_o         head instruction, INST_NOP when invalid
//   inst_addr_o    head address, 0 when invalid
//   pc_o           next address to request
// ----------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   if_fetch_if.master  rib,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic [31:0] pc_o
);

   // Control state
   logic [31:0] pc_q, pc_d;
   logic [1:0]  alloc_q, alloc_d;
   logic [1:0]  filled_q, filled_d;
   logic        head_q, head_d;
   logic        tail_q, tail_d;
   logic        fill_q, fill_d;
   logic [1:0]  kill_q, kill_d;

   // Queue payload (qualified by alloc/filled, so not reset)
   logic [31:0] addr_q [0:1];
   logic [31:0] data_q [0:1];

   logic        wr_addr_en;
   logic        wr_data_en;

   logic [1:0]  alloc_cnt;
   logic [1:0]  unfilled_cnt;
   logic [2:0]  occ_sum;
   logic        head_valid;
   logic        pop;
   logic        req_valid;
   logic        accept;

   assign alloc_cnt    = {1'b0, alloc_q[0]} + {1'b0, alloc_q[1]};
   assign unfilled_cnt = {1'b0, alloc_q[0] & ~filled_q[0]}
                       + {1'b0, alloc_q[1] & ~filled_q[1]};

   // Killed responses still occupy bus slots, so they count against capacity.
   assign occ_sum    = {1'b0, alloc_cnt} + {1'b0, kill_q};
   assign head_valid = alloc_q[head_q] & filled_q[head_q];
   assign pop        = head_valid & (hold_flag_i < 3'd2) & ~jump_flag_i;

   // A slot freed by this cycle's pop may be reused by this cycle's request.
   assign req_valid = ~rst & ~jump_flag_i & (hold_flag_i == 3'd0)
                    & ((occ_sum - {2'b00, pop}) < 3'd2);
   assign accept    = req_valid & rib.req_ready;

   assign rib.req_valid = req_valid;
   assign rib.req_addr  = pc_q;

   always_comb begin
      pc_d       = pc_q;
      alloc_d    = alloc_q;
      filled_d   = filled_q;
      head_d     = head_q;
      tail_d     = tail_q;
      fill_d     = fill_q;
      kill_d     = kill_q;
      wr_addr_en = 1'b0;
      wr_data_en = 1'b0;

      if (jump_flag_i) begin
         // Every allocated-but-unfilled entry becomes a response to discard;
         // a response landing in this very cycle is one of them and is
         // already gone.
         pc_d     = jump_addr_i;
         alloc_d  = 2'b00;
         filled_d = 2'b00;
         head_d   = 1'b0;
         tail_d   = 1'b0;
         fill_d   = 1'b0;
         kill_d   = kill_q + unfilled_cnt - {1'b0, rib.rsp_valid};
      end else begin
         if (rib.rsp_valid) begin
            if (kill_q != 2'd0) begin
               kill_d = kill_q - 2'd1;
            end else begin
               filled_d[fill_q] = 1'b1;
               fill_d           = ~fill_q;
               wr_data_en       = 1'b1;
            end
         end
         if (pop) begin
            alloc_d[head_q]  = 1'b0;
            filled_d[head_q] = 1'b0;
            head_d           = ~head_q;
         end
         // Applied after pop so a freed head slot can be reallocated at once.
         if (accept) begin
            alloc_d[tail_q]  = 1'b1;
            filled_d[tail_q] = 1'b0;
            tail_d           = ~tail_q;
            pc_d             = pc_q + 32'd4;
            wr_addr_en       = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         alloc_q  <= 2'b00;
         filled_q <= 2'b00;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         fill_q   <= 1'b0;
         kill_q   <= 2'd0;
      end else begin
         pc_q     <= pc_d;
         alloc_q  <= alloc_d;
         filled_q <= filled_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         fill_q   <= fill_d;
         kill_q   <= kill_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_addr_en) addr_q[tail_q] <= pc_q;
      if (wr_data_en) data_q[fill_q] <= rib.rsp_data;
   end

   // Outputs come only from registered queue state; no bypass from the bus.
   assign inst_valid_o = head_valid;
   assign inst_o       = head_valid ? data_q[head_q] : INST_NOP;
   assign inst_addr_o  = head_valid ? addr_q[head_q] : 32'h0000_0000;
   assign pc_o         = pc_q;

   a_occupancy: assert property (@(posedge clk) disable iff (rst) occ_sum <= 3'd2);

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch unit between the pipeline controller and the IF/ID register. It owns the program counter and issues in-order instruction reads on the rib master port, with up to 2 requests outstanding. It buffers returned words in a 2-entry queue and presents them to IF/ID. It obeys the controller's jump (flush + redirect) and hold (freeze PC / stall consumer) commands.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- INST_NOP, 32'h0000_0013, value driven on inst_o when no valid instruction
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- jump_flag_i  in  1  redirect request from ctrl; highest priority
- jump_addr_i  in  32  redirect target, word-aligned
- hold_flag_i  in  3  ctrl hold level: 0 none, 1 Pc, 2 If, 3 Id, 4 Wb
- req_valid_o  out  1  fetch request valid
- req_addr_o  out  32  fetch address (= current PC)
- req_ready_i  in  1  bus accepts request this cycle
- rsp_valid_i  in  1  read data returned, in request order, ≥1 cycle after acceptance
- rsp_data_i  in  32  returned instruction word
- inst_valid_o  out  1  queue head holds a returned instruction
- inst_o  out  32  head instruction, INST_NOP when invalid
- inst_addr_o  out  32  head address, 0 when invalid
- pc_o  out  32  current PC (next address to request)

## Operation
- State: pc (32b), 2-entry queue (per entry: alloc, filled, addr, data), head/tail/fill pointers (1b each, wrap mod 2), kill_cnt (0..2).
- Entry allocated at tail on request acceptance, with addr = pc. pc += 4 on the same edge.
- A response with kill_cnt = 0 fills the oldest unfilled entry.
- A response with kill_cnt > 0 is dropped and decrements kill_cnt.
- pop = inst_valid_o && hold_flag_i < 2 && !jump_flag_i. Pop frees the head entry.
- Issue condition: req_valid_o = !jump_flag_i && hold_flag_i == 0 && (alloc_count - pop + kill_cnt) < 2.
  - A slot freed by a same-cycle pop is reusable.
- Hold ≥1: pc frozen, no new request. In-flight responses are still accepted and fill entries.
- Hold ≥2: no pop. Queue contents are retained.
- Jump (priority over hold):
  - pc ← jump_addr_i.
  - All queue entries invalidated; pointers reset to 0.
  - kill_cnt ← kill_cnt + (allocated-unfilled entries) − (1 if a response arrives this cycle).
  - No request is issued during the jump cycle. A response arriving in the jump cycle is dropped.
- req_valid_o may fall without acceptance only in a jump or hold cycle. The bus tolerates this withdrawal.
- inst_o / inst_addr_o are driven from registered queue state only. There is no bypass from rsp_data_i.
- Invariant: alloc_count + kill_cnt ≤ 2. Violation is a design error; assert it in simulation.

## Timing
- Reset (async, takes effect immediately):
  - pc = RESET_PC, queue empty, kill_cnt = 0.
  - inst_valid_o = 0, inst_o = INST_NOP, inst_addr_o = 0, pc_o = RESET_PC.
  - req_valid_o = 0 while rst is high.
- First request: req_valid_o = 1 with addr RESET_PC in the first cycle after rst deasserts.
- Latency: request accepted at cycle N, response at N+k (k ≥ 1) → inst_valid_o = 1 at N+k+1.
- Throughput with k = 1, no hold: one instruction per cycle in steady state.
- Jump at cycle J:
  - Request for jump_addr_i at J+1, if kill_cnt + 0 < 2.
  - Stale responses after J are discarded until kill_cnt = 0.
- Reset mid-operation: all state cleared, including kill_cnt.
  - The bus is required to drop in-flight responses on the same reset.

## Test plan
- Reset release, req_ready_i = 1, 1-cycle response latency, data = addr ^ 32'hA5A5_0000 → requests 0x0, 0x4, 0x8… back to back; inst_valid_o first high 2 cycles after rst falls; inst_addr_o increments by 4 each cycle.
- Hold levels:
  - hold_flag_i = 1 for 5 cycles → req_valid_o = 0 and pc_o constant; queued instructions still pop.
  - hold_flag_i = 3 → no pop; after 2 fills, req_valid_o = 0; release resumes with no loss or duplication.
- Jump with 2 outstanding, jump_addr_i = 0x100, responses 3 cycles late → kill_cnt = 2; both stale words dropped; first inst_addr_o after jump = 0x100.
- Jump in the same cycle as a response and a pending pop → response dropped; queue empty next cycle; kill_cnt = outstanding − 1; no pop occurs.
- req_ready_i toggling pseudo-randomly, response latency random 1–4, 1000 instructions → instruction stream matches a reference address sequence; alloc_count + kill_cnt ≤ 2 every cycle.
- rst asserted mid-stream with 2 outstanding → all outputs at reset values immediately; after release, fetch restarts at RESET_PC.
